// File: rtl/flowreg_fifo.sv
// Elastic valid/ready buffer: DEPTH-entry circular queue with a registered downstream side,
// optional ready pass-through when full, and an occupancy count.
module flowreg_fifo #(
    parameter int W          = 8,
    parameter int DEPTH      = 2,
    parameter int READY_PASS = 0,
    parameter int CW         = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [W-1:0]  d_u,
    input  logic          v_u,
    output logic          r_u,
    output logic [W-1:0]  d_d,
    output logic          v_d,
    input  logic          r_d,
    output logic [CW-1:0] count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wp_q, wp_d;
    logic [PW-1:0] rp_q, rp_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          push_s, pop_s, full_s;

    // Wraps explicitly at DEPTH-1 so non-power-of-two depths index correctly.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PW'(DEPTH - 1)) begin
            return {PW{1'b0}};
        end else begin
            return p + PW'(1);
        end
    endfunction

    assign full_s = (cnt_q == CW'(DEPTH));
    assign v_d    = (cnt_q != {CW{1'b0}});
    assign d_d    = mem_q[rp_q];
    assign count  = cnt_q;

    generate
        if (READY_PASS != 0) begin : g_ready_pass
            // When full, a pop this cycle frees the slot the push lands in.
            assign r_u = ~full_s | r_d;
        end else begin : g_ready_reg
            assign r_u = ~full_s;
        end
    endgenerate

    assign push_s = v_u & r_u;
    assign pop_s  = v_d & r_d;

    // Next-state for pointers and occupancy.
    always_comb begin
        wp_d  = wp_q;
        rp_d  = rp_q;
        cnt_d = cnt_q;
        if (push_s) begin
            wp_d = ptr_inc(wp_q);
        end else begin
            wp_d = wp_q;
        end
        if (pop_s) begin
            rp_d = ptr_inc(rp_q);
        end else begin
            rp_d = rp_q;
        end
        case ({push_s, pop_s})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wp_q  <= {PW{1'b0}};
            rp_q  <= {PW{1'b0}};
            cnt_q <= {CW{1'b0}};
        end else begin
            wp_q  <= wp_d;
            rp_q  <= rp_d;
            cnt_q <= cnt_d;
        end
    end

    // Storage; cleared on reset so d_d reads zero straight out of reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {W{1'b0}};
            end
        end else if (push_s) begin
            mem_q[wp_q] <= d_u;
        end else begin
            mem_q[wp_q] <= mem_q[wp_q];
        end
    end

endmodule

// File: tb/tb_flowreg_fifo.sv
// Directed bench for flowreg_fifo: three instances cover DEPTH=3/RP=0, DEPTH=2/RP=1 and DEPTH=1/RP=0.
module tb_flowreg_fifo;

    logic clk;
    logic rst;

    logic [7:0] d_u_a, d_d_a;
    logic       v_u_a, r_u_a, v_d_a, r_d_a;
    logic [1:0] count_a;

    logic [7:0] d_u_b, d_d_b;
    logic       v_u_b, r_u_b, v_d_b, r_d_b;
    logic [1:0] count_b;

    logic [7:0] d_u_c, d_d_c;
    logic       v_u_c, r_u_c, v_d_c, r_d_c;
    logic [0:0] count_c;

    int total = 0;
    int bad   = 0;
    int nin, nout, npush, npop;

    flowreg_fifo #(.W(8), .DEPTH(3), .READY_PASS(0)) u_a (
        .clk(clk), .rst(rst), .d_u(d_u_a), .v_u(v_u_a), .r_u(r_u_a),
        .d_d(d_d_a), .v_d(v_d_a), .r_d(r_d_a), .count(count_a)
    );

    flowreg_fifo #(.W(8), .DEPTH(2), .READY_PASS(1)) u_b (
        .clk(clk), .rst(rst), .d_u(d_u_b), .v_u(v_u_b), .r_u(r_u_b),
        .d_d(d_d_b), .v_d(v_d_b), .r_d(r_d_b), .count(count_b)
    );

    flowreg_fifo #(.W(8), .DEPTH(1), .READY_PASS(0)) u_c (
        .clk(clk), .rst(rst), .d_u(d_u_c), .v_u(v_u_c), .r_u(r_u_c),
        .d_d(d_d_c), .v_d(v_d_c), .r_d(r_d_c), .count(count_c)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst   = 1'b0;
        d_u_a = 8'h00; v_u_a = 1'b0; r_d_a = 1'b0;
        d_u_b = 8'h00; v_u_b = 1'b0; r_d_b = 1'b0;
        d_u_c = 8'h00; v_u_c = 1'b0; r_d_c = 1'b0;
        #3;
        check_val("rst_vd", v_d_a, 0);
        check_val("rst_count", count_a, 0);
        check_val("rst_dd", d_d_a, 0);
        check_val("rst_ru_a", r_u_a, 1);
        check_val("rst_ru_b", r_u_b, 1);
        check_val("rst_ru_c", r_u_c, 1);
        tick();
        tick();
        rst = 1'b1;

        // Fill/drain on DEPTH=3
        v_u_a = 1'b1; d_u_a = 8'h11; tick();
        check_val("fill1_count", count_a, 1);
        check_val("fill1_vd", v_d_a, 1);
        check_val("fill1_dd", d_d_a, 8'h11);
        d_u_a = 8'h22; tick();
        check_val("fill2_count", count_a, 2);
        d_u_a = 8'h33; tick();
        check_val("fill3_count", count_a, 3);
        check_val("fill3_ru", r_u_a, 0);
        d_u_a = 8'h44; tick();
        check_val("stall_count", count_a, 3);
        check_val("stall_ru", r_u_a, 0);
        check_val("stall_dd", d_d_a, 8'h11);
        r_d_a = 1'b1; tick();
        check_val("drain1_dd", d_d_a, 8'h22);
        check_val("drain1_count", count_a, 2);
        check_val("drain1_ru", r_u_a, 1);
        tick();
        check_val("drain2_dd", d_d_a, 8'h33);
        check_val("drain2_count", count_a, 2);
        v_u_a = 1'b0; tick();
        check_val("drain3_dd", d_d_a, 8'h44);
        check_val("drain3_count", count_a, 1);
        tick();
        check_val("drain4_vd", v_d_a, 0);
        check_val("drain4_count", count_a, 0);

        // Asynchronous reset with two entries held
        r_d_a = 1'b0; v_u_a = 1'b1; d_u_a = 8'hA1; tick();
        d_u_a = 8'hA2; tick();
        v_u_a = 1'b0;
        check_val("pre_rst_count", count_a, 2);
        rst = 1'b0;
        #1;
        check_val("mid_rst_vd", v_d_a, 0);
        check_val("mid_rst_count", count_a, 0);
        check_val("mid_rst_dd", d_d_a, 0);
        check_val("mid_rst_ru", r_u_a, 1);
        tick();
        rst = 1'b1;

        // Wrap-around: 0..9 with r_d toggling 1,0,1,...
        nin = 0; nout = 0;
        for (int cyc = 0; cyc < 60 && nout < 10; cyc++) begin
            v_u_a = (nin < 10);
            d_u_a = 8'(nin);
            r_d_a = (cyc % 2 == 0);
            #1;
            if (v_d_a && r_d_a) begin
                check_val("wrap_data", d_d_a, nout);
                nout++;
            end
            if (v_u_a && r_u_a) nin++;
            tick();
        end
        v_u_a = 1'b0; r_d_a = 1'b0;
        check_val("wrap_nout", nout, 10);
        check_val("wrap_empty", count_a, 0);

        // Full-throughput pass on DEPTH=2, READY_PASS=1
        v_u_b = 1'b1; d_u_b = 8'h50; tick();
        d_u_b = 8'h51; tick();
        check_val("pass_fill_count", count_b, 2);
        check_val("pass_fill_ru", r_u_b, 0);
        npush = 0; npop = 0;
        for (int i = 0; i < 6; i++) begin
            d_u_b = 8'h52 + 8'(i);
            r_d_b = 1'b1;
            #1;
            check_val("pass_ru", r_u_b, 1);
            check_val("pass_dd", d_d_b, 8'h50 + 8'(i));
            if (v_u_b && r_u_b) npush++;
            if (v_d_b && r_d_b) npop++;
            tick();
            check_val("pass_count", count_b, 2);
        end
        check_val("pass_npush", npush, 6);
        check_val("pass_npop", npop, 6);
        v_u_b = 1'b0; tick();
        check_val("pass_tail_dd", d_d_b, 8'h57);
        r_d_b = 1'b0;

        // Half-rate on DEPTH=1, READY_PASS=0
        npush = 0; npop = 0;
        v_u_c = 1'b1; r_d_c = 1'b1;
        for (int i = 0; i < 8; i++) begin
            d_u_c = 8'h60 + 8'(npush);
            #1;
            check_val("half_vd", v_d_c, (i % 2 == 1));
            if (v_d_c && r_d_c) begin
                check_val("half_dd", d_d_c, 8'h60 + 8'(npop));
                npop++;
            end
            if (v_u_c && r_u_c) npush++;
            tick();
        end
        v_u_c = 1'b0; r_d_c = 1'b0;
        check_val("half_npush", npush, 4);
        check_val("half_npop", npop, 4);

        // Backpressure stability on DEPTH=3
        v_u_a = 1'b1; d_u_a = 8'h77; tick();
        npush = 0;
        for (int i = 0; i < 5; i++) begin
            d_u_a = 8'h90 + 8'(npush);
            #1;
            if (v_u_a && r_u_a) npush++;
            tick();
            check_val("bp_vd", v_d_a, 1);
            check_val("bp_dd", d_d_a, 8'h77);
        end
        check_val("bp_count", count_a, 3);
        v_u_a = 1'b0; r_d_a = 1'b1; tick();
        check_val("bp_drain1", d_d_a, 8'h90);
        tick();
        check_val("bp_drain2", d_d_a, 8'h91);
        tick();
        check_val("bp_drain_empty", count_a, 0);
        r_d_a = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
